// File: rtl/hw_accel_unpack_rgb_gray.sv
// Unpacks 32-bit packed words into one RGB888 or grayscale pixel per handshake,
// dropping end-of-frame padding bytes left in the buffer after the last pixel.
module hw_accel_unpack_rgb_gray #(
  parameter int PACK_MODE    = 0,
  parameter int FRAME_PIXELS = 9216
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_restart,
  input  logic [31:0] in_packed_data,
  input  logic        in_packed_data_valid,
  output logic        in_packed_data_ready,
  output logic [23:0] out_pixel_data,
  output logic [7:0]  out_gray_pixel_data,
  output logic        out_pixel_data_valid,
  input  logic        out_pixel_data_ready,
  output logic        out_pixel_data_last
);

  // Handshakes: a word moves when in_packed_data_valid && in_packed_data_ready,
  // a pixel moves when out_pixel_data_valid && out_pixel_data_ready. Both ready
  // and valid are decoded from registered state only.

  localparam int              BPP      = (PACK_MODE == 2) ? 1 : 3;
  localparam int              PW       = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [3:0]      BPP4     = 4'(BPP);
  localparam logic [PW-1:0]   LAST_IDX = PW'(FRAME_PIXELS - 1);

  logic [63:0]   byte_q;
  logic [3:0]    cnt_q;
  logic [PW-1:0] pix_cnt_q;

  logic          accept;
  logic          pop;
  logic          last;
  logic [3:0]    shift;
  logic [3:0]    keep;
  logic [63:0]   shifted;
  logic [63:0]   keep_mask;
  logic [63:0]   appended;
  logic [63:0]   byte_d;
  logic [3:0]    cnt_d;
  logic [7:0]    b0;
  logic [7:0]    b1;
  logic [7:0]    b2;

  assign in_packed_data_ready = (cnt_q <= 4'd4);
  assign out_pixel_data_valid = (cnt_q >= BPP4);
  assign accept               = in_packed_data_valid && in_packed_data_ready;
  assign pop                  = out_pixel_data_valid && out_pixel_data_ready;
  assign last                 = out_pixel_data_valid && (pix_cnt_q == LAST_IDX);
  assign out_pixel_data_last  = last;

  // Surviving bytes slide to the head; an end-of-frame pop keeps none of them.
  // A new word lands right after the survivors, which is at most byte 4.
  always_comb begin
    shift     = pop ? BPP4 : 4'd0;
    keep      = (pop && last) ? 4'd0 : (cnt_q - shift);
    shifted   = byte_q >> {shift, 3'b000};
    keep_mask = ~({64{1'b1}} << {keep, 3'b000});
    appended  = accept ? ({32'h0, in_packed_data} << {keep, 3'b000}) : 64'h0;
    byte_d    = (shifted & keep_mask) | appended;
    cnt_d     = keep + (accept ? 4'd4 : 4'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q    <= 64'h0;
      cnt_q     <= 4'd0;
      pix_cnt_q <= '0;
    end else if (frame_restart) begin
      cnt_q     <= 4'd0;
      pix_cnt_q <= '0;
    end else begin
      byte_q <= byte_d;
      cnt_q  <= cnt_d;
      if (pop) begin
        pix_cnt_q <= last ? '0 : pix_cnt_q + 1'b1;
      end
    end
  end

  assign b0 = byte_q[7:0];
  assign b1 = byte_q[15:8];
  assign b2 = byte_q[23:16];

  always_comb begin
    out_pixel_data      = 24'h0;
    out_gray_pixel_data = 8'h0;
    if (cnt_q != 4'd0) begin
      case (PACK_MODE)
        1: begin
          out_pixel_data      = {b2, b1, b0};
          out_gray_pixel_data = b2;
        end
        2: begin
          out_pixel_data      = {b0, b0, b0};
          out_gray_pixel_data = b0;
        end
        default: begin
          out_pixel_data      = {b0, b1, b2};
          out_gray_pixel_data = b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hw_accel_unpack_rgb_gray.sv
// Bench for hw_accel_unpack_rgb_gray: three instances (modes 0/1/2) checked
// against a byte-queue reference model plus directed scenario checks.
module tb_hw_accel_unpack_rgb_gray;

  logic        clk;
  logic        rst;
  logic        frame_restart [3];
  logic [31:0] in_data       [3];
  logic        in_valid      [3];
  logic        in_ready      [3];
  logic [23:0] pix           [3];
  logic [7:0]  gray          [3];
  logic        out_valid     [3];
  logic        out_ready     [3];
  logic        out_last      [3];

  logic [7:0]  mq [3][$];
  int          pc [3];
  int          checks;
  int          errors;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hw_accel_unpack_rgb_gray #(
      .PACK_MODE   (g),
      .FRAME_PIXELS((g == 0) ? 5 : ((g == 1) ? 7 : 6))
    ) u_dut (
      .clk                 (clk),
      .rst                 (rst),
      .frame_restart       (frame_restart[g]),
      .in_packed_data      (in_data[g]),
      .in_packed_data_valid(in_valid[g]),
      .in_packed_data_ready(in_ready[g]),
      .out_pixel_data      (pix[g]),
      .out_gray_pixel_data (gray[g]),
      .out_pixel_data_valid(out_valid[g]),
      .out_pixel_data_ready(out_ready[g]),
      .out_pixel_data_last (out_last[g])
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  function automatic int fpx(input int d);
    return (d == 0) ? 5 : ((d == 1) ? 7 : 6);
  endfunction

  // One clock of traffic on instance d; the scoreboard compares the DUT
  // against the byte queue, then the queue consumes/appends like the spec says.
  task automatic cyc(input int d, input logic v, input logic [31:0] w, input logic r,
                     input logic fr, output logic acc, output logic pp, output logic ov,
                     output logic lst, output logic ordy, output logic [23:0] opix,
                     output logic [7:0] ogray);
    int sz, bpp;
    logic er, ev, el;
    logic [23:0] ep;
    logic [7:0]  eg;
    @(negedge clk);
    in_valid[d] = v; in_data[d] = w; out_ready[d] = r; frame_restart[d] = fr;
    #1;
    sz  = mq[d].size();
    bpp = (d == 2) ? 1 : 3;
    er  = (sz <= 4);
    ev  = (sz >= bpp);
    el  = ev && (pc[d] == fpx(d) - 1);
    ep  = 24'h0;
    eg  = 8'h0;
    if (ev) begin
      if (d == 0) begin ep = {mq[d][0], mq[d][1], mq[d][2]}; eg = mq[d][0]; end
      else if (d == 1) begin ep = {mq[d][2], mq[d][1], mq[d][0]}; eg = mq[d][2]; end
      else begin ep = {mq[d][0], mq[d][0], mq[d][0]}; eg = mq[d][0]; end
    end
    checks++;
    if ({in_ready[d], out_valid[d], out_last[d]} !== {er, ev, el}) begin
      errors++;
      $display("FAIL sb_handshake dut%0d: ready/valid/last got %b%b%b want %b%b%b",
               d, in_ready[d], out_valid[d], out_last[d], er, ev, el);
    end
    if (ev || sz == 0) begin
      checks++;
      if (pix[d] !== ep || gray[d] !== eg) begin
        errors++;
        $display("FAIL sb_data dut%0d: pixel %h gray %h want %h %h", d, pix[d], gray[d], ep, eg);
      end
    end
    acc = v && in_ready[d]; pp = r && out_valid[d]; ov = out_valid[d];
    lst = out_last[d]; ordy = in_ready[d]; opix = pix[d]; ogray = gray[d];
    if (fr) begin
      mq[d].delete();
      pc[d] = 0;
    end else begin
      if (r && ev) begin
        for (int b = 0; b < bpp; b++) void'(mq[d].pop_front());
        if (el) begin
          mq[d].delete();
          pc[d] = 0;
        end else begin
          pc[d]++;
        end
      end
      if (v && er) begin
        for (int b = 0; b < 4; b++) mq[d].push_back(w[8*b +: 8]);
      end
    end
  endtask

  task automatic restart(input int d);
    logic a, p, o, l, y; logic [23:0] x; logic [7:0] gg;
    cyc(d, 1'b0, 32'h0, 1'b0, 1'b1, a, p, o, l, y, x, gg);
    cyc(d, 1'b0, 32'h0, 1'b0, 1'b0, a, p, o, l, y, x, gg);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      frame_restart[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = 32'h0;
      out_ready[d] = 1'b0; pc[d] = 0; mq[d].delete();
    end
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || out_last[d] !== 1'b0 ||
          pix[d] !== 24'h0 || gray[d] !== 8'h0) begin
        errors++;
        $display("FAIL reset_values dut%0d: rdy %b vld %b last %b pix %h gray %h want 1 0 0 0 0",
                 d, in_ready[d], out_valid[d], out_last[d], pix[d], gray[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rgb_order(input int d, input logic [23:0] e0, input logic [23:0] e1,
                                input logic [23:0] e2, input logic [23:0] e3);
    logic [31:0] words [3];
    logic [23:0] exp_px [4];
    logic a, p, o, l, y; logic [23:0] x; logic [7:0] gg;
    int k, n, first;
    words  = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};
    exp_px = '{e0, e1, e2, e3};
    k = 0; n = 0; first = -1;
    restart(d);
    for (int i = 0; i < 30 && n < 4; i++) begin
      cyc(d, k < 3, (k < 3) ? words[k] : 32'h0, 1'b1, 1'b0, a, p, o, l, y, x, gg);
      if (a) k++;
      if (p) begin
        if (first < 0) first = i;
        checks++;
        if (x !== exp_px[n]) begin
          errors++;
          $display("FAIL order_mode%0d pixel %0d: got %h want %h", d, n, x, exp_px[n]);
        end
        n++;
      end
    end
    checks++;
    if (first != 1 || n != 4) begin
      errors++;
      $display("FAIL order_mode%0d latency/count: first pop cycle %0d pops %0d want 1 4", d, first, n);
    end
    restart(d);
  endtask

  task automatic test_gray_order();
    logic [7:0] exp_g [4];
    logic a, p, o, l, y; logic [23:0] x; logic [7:0] gg;
    exp_g = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    restart(2);
    for (int i = 0; i < 6; i++) begin
      cyc(2, i == 0, 32'hDDCCBBAA, 1'b1, 1'b0, a, p, o, l, y, x, gg);
      checks++;
      if (y !== 1'b1) begin
        errors++;
        $display("FAIL gray_ready cycle %0d: in_ready %b want 1", i, y);
      end
      if (i >= 1 && i <= 4) begin
        checks++;
        if (p !== 1'b1 || gg !== exp_g[i-1]) begin
          errors++;
          $display("FAIL gray_order cycle %0d: pop %b gray %h want 1 %h", i, p, gg, exp_g[i-1]);
        end
      end
      if (i == 1) begin
        checks++;
        if (x !== 24'hAAAAAA) begin
          errors++;
          $display("FAIL gray_rgb: got %h want aaaaaa", x);
        end
      end
    end
    restart(2);
  endtask

  task automatic test_back_pressure();
    logic a, p, o, l, y; logic [23:0] x; logic [7:0] gg;
    logic [23:0] held;
    int nacc;
    logic have;
    nacc = 0; have = 1'b0; held = 24'h0; y = 1'b1;
    restart(0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1'b1, $urandom, 1'b0, 1'b0, a, p, o, l, y, x, gg);
      if (a) nacc++;
      if (o) begin
        if (!have) begin
          held = x; have = 1'b1;
        end else begin
          checks++;
          if (x !== held) begin
            errors++;
            $display("FAIL bp_stable cycle %0d: pixel %h want %h", i, x, held);
          end
        end
      end
    end
    checks++;
    if (nacc != 2 || y !== 1'b0) begin
      errors++;
      $display("FAIL bp_accepts: accepted %0d ready %b want 2 0", nacc, y);
    end
    for (int i = 0; i < 40; i++) cyc(0, 1'b1, $urandom, 1'b1, 1'b0, a, p, o, l, y, x, gg);
    for (int i = 0; i < 8; i++)  cyc(0, 1'b0, 32'h0, 1'b1, 1'b0, a, p, o, l, y, x, gg);
    restart(0);
  endtask

  task automatic test_frame_padding(input logic same_cycle);
    logic [31:0] base [4];
    logic a, p, o, l, y; logic [23:0] x; logic [7:0] gg;
    logic v, got_last, done;
    logic [31:0] w;
    int k, n;
    base = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
    k = 0; n = 0; got_last = 1'b0; done = 1'b0;
    restart(0);
    for (int i = 0; i < 80 && !done; i++) begin
      if (k < 4) begin v = 1'b1; w = base[k]; end
      else if (k == 4) begin v = same_cycle || got_last; w = 32'h04030201; end
      else begin v = 1'b1; w = $urandom; end
      cyc(0, v, w, 1'b1, 1'b0, a, p, o, l, y, x, gg);
      if (a) k++;
      if (p) begin
        n++;
        if (n == 5) begin
          got_last = 1'b1;
          checks++;
          if (l !== 1'b1 || x !== 24'h1C1D1E || (same_cycle && !(a && k == 5))) begin
            errors++;
            $display("FAIL pad_last same=%0b: last %b pixel %h acc %b want 1 1c1d1e %b",
                     same_cycle, l, x, a, same_cycle);
          end
        end else if (n == 6) begin
          checks++;
          if (x !== 24'h010203) begin
            errors++;
            $display("FAIL pad_next same=%0b: pixel %h want 010203", same_cycle, x);
          end
        end else if (n > 6 && l) begin
          checks++;
          if (n != 10) begin
            errors++;
            $display("FAIL pad_frame2 same=%0b: last on pop %0d want 10", same_cycle, n);
          end
          done = 1'b1;
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL pad_timeout same=%0b: pops %0d want 10", same_cycle, n);
    end
    restart(0);
  endtask

  task automatic test_frame_restart();
    logic a, p, o, l, y; logic [23:0] x; logic [7:0] gg;
    int n, k;
    logic done;
    n = 0; k = 0; done = 1'b0;
    restart(1);
    for (int i = 0; i < 20 && n < 2; i++) begin
      cyc(1, 1'b1, $urandom, 1'b1, 1'b0, a, p, o, l, y, x, gg);
      if (p) n++;
    end
    cyc(1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, a, p, o, l, y, x, gg);
    n = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      cyc(1, 1'b1, (k == 0) ? 32'h44332211 : $urandom, 1'b1, 1'b0, a, p, o, l, y, x, gg);
      if (a) k++;
      if (p) begin
        n++;
        if (n == 1) begin
          checks++;
          if (x !== 24'h332211) begin
            errors++;
            $display("FAIL restart_first: pixel %h want 332211", x);
          end
        end
        if (l) begin
          checks++;
          if (n != 7) begin
            errors++;
            $display("FAIL restart_last: last on pop %0d want 7", n);
          end
          done = 1'b1;
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL restart_timeout: pops %0d want 7", n);
    end
    restart(1);
  endtask

  task automatic test_random(input int d);
    logic a, p, o, l, y; logic [23:0] x; logic [7:0] gg;
    restart(d);
    for (int i = 0; i < 400; i++) begin
      cyc(d, $urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 7,
          $urandom_range(0, 63) == 0, a, p, o, l, y, x, gg);
    end
    restart(d);
  endtask

  task automatic test_mid_reset();
    logic a, p, o, l, y; logic [23:0] x; logic [7:0] gg;
    restart(0);
    for (int i = 0; i < 4; i++) cyc(0, 1'b1, $urandom, 1'b0, 1'b0, a, p, o, l, y, x, gg);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || out_last[d] !== 1'b0 ||
          pix[d] !== 24'h0 || gray[d] !== 8'h0) begin
        errors++;
        $display("FAIL mid_reset dut%0d: rdy %b vld %b last %b pix %h gray %h want 1 0 0 0 0",
                 d, in_ready[d], out_valid[d], out_last[d], pix[d], gray[d]);
      end
      mq[d].delete();
      pc[d] = 0;
    end
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) cyc(0, 1'b1, $urandom, 1'b1, 1'b0, a, p, o, l, y, x, gg);
    restart(0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_rgb_order(0, 24'h112233, 24'h445566, 24'h778899, 24'hAABBCC);
    test_rgb_order(1, 24'h332211, 24'h665544, 24'h998877, 24'hCCBBAA);
    test_gray_order();
    test_back_pressure();
    test_frame_padding(1'b0);
    test_frame_padding(1'b1);
    test_frame_restart();
    for (int d = 0; d < 3; d++) test_random(d);
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
